// File: rtl/path_accum_engine.sv
// Path-count accumulator: walks an adjacency memory breadth-first from a start node and
// sums the number of distinct paths reaching the end node. Optional macro: PATH_ACCUM_SATURATE_EN.
module path_accum_engine #(
    parameter int NODE_IDX_WIDTH  = 9,
    parameter int COUNTER_WIDTH   = 4,
    parameter int ACCUM_VAL_WIDTH = 48,
    parameter int FIFO_DEPTH      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_run,
    input  logic [NODE_IDX_WIDTH-1:0]  start_node_idx,
    input  logic [NODE_IDX_WIDTH-1:0]  end_node_idx,
    output logic                       mem_rd_en,
    output logic [NODE_IDX_WIDTH-1:0]  mem_node_idx,
    output logic [COUNTER_WIDTH-1:0]   mem_edge_sel,
    input  logic [COUNTER_WIDTH-1:0]   mem_edge_count,
    input  logic [NODE_IDX_WIDTH-1:0]  mem_next_node_idx,
    output logic                       busy,
    output logic                       result_valid,
    output logic [ACCUM_VAL_WIDTH-1:0] result,
    output logic                       err_fifo_full,
    output logic                       err_saturated
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, POP, EDGE_REQ, EDGE_RSP, DONE, ERROR} state_t;

    state_t                     state;
    logic [NODE_IDX_WIDTH-1:0]  q_node [FIFO_DEPTH];
    logic [ACCUM_VAL_WIDTH-1:0] q_cnt  [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]      q_vld;
    logic [PW-1:0]              rd_ptr, wr_ptr;
    logic [NODE_IDX_WIDTH-1:0]  start_q, end_q, cur_node;
    logic [ACCUM_VAL_WIDTH-1:0] cur_count, end_acc;
    logic [COUNTER_WIDTH-1:0]   k;

    logic                       hit, is_end, full, empty;
    logic [PW-1:0]              hit_idx;
    logic [COUNTER_WIDTH-1:0]   k_next;
    logic [ACCUM_VAL_WIDTH-1:0] add_a, sum;
`ifdef PATH_ACCUM_SATURATE_EN
    logic [ACCUM_VAL_WIDTH:0]   sum_wide;
    logic                       sat_hit;
`endif

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        // Queue holds at most one entry per node, so the first hit is the only one.
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (!hit && q_vld[i] && q_node[i] == mem_next_node_idx) begin
                hit     = 1'b1;
                hit_idx = PW'(i);
            end
        end
        is_end = (mem_next_node_idx == end_q);
        full   = (rd_ptr == wr_ptr) && q_vld[rd_ptr];
        empty  = (rd_ptr == wr_ptr) && !q_vld[rd_ptr];
        k_next = k + 1'b1;
        add_a  = is_end ? end_acc : q_cnt[hit_idx];
`ifdef PATH_ACCUM_SATURATE_EN
        sum_wide = {1'b0, add_a} + {1'b0, cur_count};
        sat_hit  = sum_wide[ACCUM_VAL_WIDTH];
        sum      = sat_hit ? '1 : sum_wide[ACCUM_VAL_WIDTH-1:0];
`else
        sum      = add_a + cur_count;
`endif
    end

`ifndef PATH_ACCUM_SATURATE_EN
    assign err_saturated = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            q_vld         <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            start_q       <= '0;
            end_q         <= '0;
            cur_node      <= '0;
            cur_count     <= '0;
            end_acc       <= '0;
            k             <= '0;
            mem_rd_en     <= 1'b0;
            mem_node_idx  <= '0;
            mem_edge_sel  <= '0;
            busy          <= 1'b0;
            result_valid  <= 1'b0;
            result        <= '0;
            err_fifo_full <= 1'b0;
`ifdef PATH_ACCUM_SATURATE_EN
            err_saturated <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start_run) begin
                        start_q       <= start_node_idx;
                        end_q         <= end_node_idx;
                        q_vld         <= '0;
                        rd_ptr        <= '0;
                        wr_ptr        <= '0;
                        end_acc       <= '0;
                        result_valid  <= 1'b0;
                        result        <= '0;
                        err_fifo_full <= 1'b0;
`ifdef PATH_ACCUM_SATURATE_EN
                        err_saturated <= 1'b0;
`endif
                        busy          <= 1'b1;
                        state         <= LOAD;
                    end
                end
                LOAD: begin
                    if (start_q == end_q) begin
                        end_acc      <= ACCUM_VAL_WIDTH'(1);
                        result       <= ACCUM_VAL_WIDTH'(1);
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= DONE;
                    end else begin
                        q_node[wr_ptr] <= start_q;
                        q_cnt[wr_ptr]  <= ACCUM_VAL_WIDTH'(1);
                        q_vld[wr_ptr]  <= 1'b1;
                        wr_ptr         <= wr_ptr + 1'b1;
                        state          <= POP;
                    end
                end
                POP: begin
                    if (empty) begin
                        result       <= end_acc;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= DONE;
                    end else begin
                        cur_node      <= q_node[rd_ptr];
                        cur_count     <= q_cnt[rd_ptr];
                        q_vld[rd_ptr] <= 1'b0;
                        rd_ptr        <= rd_ptr + 1'b1;
                        k             <= '0;
                        mem_rd_en     <= 1'b1;
                        mem_node_idx  <= q_node[rd_ptr];
                        mem_edge_sel  <= '0;
                        state         <= EDGE_REQ;
                    end
                end
                EDGE_REQ: begin
                    mem_rd_en <= 1'b0;
                    state     <= EDGE_RSP;
                end
                EDGE_RSP: begin
                    if (mem_edge_count == '0) begin
                        state <= POP;
                    end else if (!is_end && !hit && full) begin
                        err_fifo_full <= 1'b1;
                        busy          <= 1'b0;
                        state         <= ERROR;
                    end else begin
                        if (is_end) begin
                            end_acc <= sum;
                        end else if (hit) begin
                            q_cnt[hit_idx] <= sum;
                        end else begin
                            q_node[wr_ptr] <= mem_next_node_idx;
                            q_cnt[wr_ptr]  <= cur_count;
                            q_vld[wr_ptr]  <= 1'b1;
                            wr_ptr         <= wr_ptr + 1'b1;
                        end
`ifdef PATH_ACCUM_SATURATE_EN
                        if ((is_end || hit) && sat_hit) err_saturated <= 1'b1;
`endif
                        if (k_next == mem_edge_count) begin
                            state <= POP;
                        end else begin
                            k            <= k_next;
                            mem_rd_en    <= 1'b1;
                            mem_node_idx <= cur_node;
                            mem_edge_sel <= k_next;
                            state        <= EDGE_REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_path_accum_engine.sv
// Directed bench for path_accum_engine: three instances (default, 2-entry queue, 4-bit count)
// each driven by a small behavioural adjacency memory.
module tb_path_accum_engine;
    localparam int NW = 9;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start_run [3];
    logic [NW-1:0] sn [3];
    logic [NW-1:0] en [3];
    logic          rd_en [3];
    logic [NW-1:0] mnode [3];
    logic [CW-1:0] msel [3];
    logic [CW-1:0] mcnt [3];
    logic [NW-1:0] mnext [3];
    logic          busy [3];
    logic          rv [3];
    logic          efull [3];
    logic          esat [3];
    logic [47:0]   res_m, res_f;
    logic [3:0]    res_w;
    int            graph [3];

    int total = 0;
    int passed = 0;

    path_accum_engine dut_m (
        .clk(clk), .rst(rst), .start_run(start_run[0]), .start_node_idx(sn[0]), .end_node_idx(en[0]),
        .mem_rd_en(rd_en[0]), .mem_node_idx(mnode[0]), .mem_edge_sel(msel[0]),
        .mem_edge_count(mcnt[0]), .mem_next_node_idx(mnext[0]), .busy(busy[0]),
        .result_valid(rv[0]), .result(res_m), .err_fifo_full(efull[0]), .err_saturated(esat[0]));

    path_accum_engine #(.FIFO_DEPTH(2)) dut_f (
        .clk(clk), .rst(rst), .start_run(start_run[1]), .start_node_idx(sn[1]), .end_node_idx(en[1]),
        .mem_rd_en(rd_en[1]), .mem_node_idx(mnode[1]), .mem_edge_sel(msel[1]),
        .mem_edge_count(mcnt[1]), .mem_next_node_idx(mnext[1]), .busy(busy[1]),
        .result_valid(rv[1]), .result(res_f), .err_fifo_full(efull[1]), .err_saturated(esat[1]));

    path_accum_engine #(.ACCUM_VAL_WIDTH(4)) dut_w (
        .clk(clk), .rst(rst), .start_run(start_run[2]), .start_node_idx(sn[2]), .end_node_idx(en[2]),
        .mem_rd_en(rd_en[2]), .mem_node_idx(mnode[2]), .mem_edge_sel(msel[2]),
        .mem_edge_count(mcnt[2]), .mem_next_node_idx(mnext[2]), .busy(busy[2]),
        .result_valid(rv[2]), .result(res_w), .err_fifo_full(efull[2]), .err_saturated(esat[2]));

    // Graphs: 0 chain 0->1->2; 1 diamond; 2 fan-out of 3 from node 0; 3 layered, 16 paths 0->9.
    function automatic logic [CW+NW-1:0] lookup(input int g, input logic [NW-1:0] n, input logic [CW-1:0] s);
        int c;
        int nx;
        c = 0;
        nx = 0;
        case (g)
            0: if (n < 2) begin c = 1; nx = n + 1; end
            1: case (n)
                   0: begin c = 2; nx = 1 + s; end
                   1, 2: begin c = 1; nx = 3; end
                   3: begin c = 1; nx = 4; end
                   default: ;
               endcase
            2: if (n == 0) begin c = 3; nx = 1 + s; end
            3: if (n == 0) begin c = 2; nx = 1 + s; end
               else if (n <= 6) begin c = 2; nx = (n + 1) / 2 * 2 + 1 + s; end
               else if (n <= 8) begin c = 1; nx = 9; end
            default: ;
        endcase
        return {c[CW-1:0], nx[NW-1:0]};
    endfunction

    for (genvar d = 0; d < 3; d++) begin : g_mem
        always @(posedge clk)
            if (rd_en[d]) {mcnt[d], mnext[d]} <= lookup(graph[d], mnode[d], msel[d]);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [47:0] res_of(input int d);
        case (d)
            0: return res_m;
            1: return res_f;
            default: return {44'd0, res_w};
        endcase
    endfunction

    // Drives a one-cycle start pulse; returns at the negedge after the accepting edge.
    task automatic kick(input int d, input logic [NW-1:0] s, input logic [NW-1:0] e);
        @(negedge clk);
        sn[d] = s;
        en[d] = e;
        start_run[d] = 1'b1;
        @(negedge clk);
        start_run[d] = 1'b0;
    endtask

    task automatic wait_end(input int d, input int budget, output int cyc, output int pulses);
        cyc = 1;
        pulses = 0;
        while (!(rv[d] || efull[d]) && cyc < budget) begin
            if (rd_en[d]) pulses++;
            @(negedge clk);
            cyc++;
        end
        chk("no_timeout", cyc < budget, 1);
    endtask

    int cyc, pulses, guard;

    initial begin
        rst = 1'b1;
        graph[0] = 0;
        graph[1] = 2;
        graph[2] = 3;
        for (int i = 0; i < 3; i++) begin
            start_run[i] = 1'b0;
            sn[i] = '0;
            en[i] = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", busy[i], 0);
            chk("rst_valid", rv[i], 0);
            chk("rst_result", res_of(i), 0);
            chk("rst_rd_en", rd_en[i], 0);
        end
        rst = 1'b0;

        // Chain 0->1->2: one path, two reads.
        kick(0, 0, 2);
        wait_end(0, 200, cyc, pulses);
        chk("chain_valid", rv[0], 1);
        chk("chain_result", res_m, 1);
        chk("chain_reads", pulses, 2);
        chk("chain_busy", busy[0], 0);
        repeat (3) @(negedge clk);
        chk("done_hold_valid", rv[0], 1);
        chk("done_hold_result", res_m, 1);

        // Diamond restarted from DONE: two paths, node 3 expanded once (5 reads).
        graph[0] = 1;
        kick(0, 0, 4);
        wait_end(0, 200, cyc, pulses);
        chk("diamond_result", res_m, 2);
        chk("diamond_reads", pulses, 5);

        // Start equal to end: DONE on the edge after LOAD, no reads.
        kick(0, 5, 5);
        wait_end(0, 200, cyc, pulses);
        chk("same_cycles", cyc, 2);
        chk("same_result", res_m, 1);
        chk("same_reads", pulses, 0);

        // Fan-out of 3 into a 2-entry queue.
        kick(1, 0, 9);
        wait_end(1, 200, cyc, pulses);
        chk("fifo_err", efull[1], 1);
        chk("fifo_valid", rv[1], 0);
        chk("fifo_busy", busy[1], 0);
        repeat (2) @(negedge clk);
        chk("fifo_err_hold", efull[1], 1);
        graph[1] = 0;
        kick(1, 0, 2);
        wait_end(1, 200, cyc, pulses);
        chk("err_restart_result", res_f, 1);
        chk("err_restart_flag", efull[1], 0);

        // 16 paths into a 4-bit accumulator.
        kick(2, 0, 9);
        wait_end(2, 400, cyc, pulses);
        chk("wide_valid", rv[2], 1);
`ifdef PATH_ACCUM_SATURATE_EN
        chk("wide_result", res_w, 15);
        chk("wide_sat", esat[2], 1);
`else
        chk("wide_result", res_w, 0);
        chk("wide_sat", esat[2], 0);
`endif

        // Reset while in EDGE_RSP.
        kick(0, 0, 4);
        guard = 0;
        while (!rd_en[0] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("saw_rd_en", rd_en[0], 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy[0], 0);
        chk("midrst_valid", rv[0], 0);
        chk("midrst_result", res_m, 0);
        chk("midrst_rd_en", rd_en[0], 0);
        chk("midrst_node", mnode[0], 0);
        chk("midrst_sel", msel[0], 0);

        // Fresh run; a second start while busy (end 1) must be ignored.
        kick(0, 0, 4);
        chk("busy_in_load", busy[0], 1);
        en[0] = 1;
        start_run[0] = 1'b1;
        @(negedge clk);
        start_run[0] = 1'b0;
        wait_end(0, 200, cyc, pulses);
        chk("after_rst_result", res_m, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/path_accum_engine.md
PATH_ACCUM_ENGINE -- requirements
Module: path_accum_engine

Interface
REQ-001 Parameters: NODE_IDX_WIDTH, default 9, node index width; COUNTER_WIDTH, default 4, edge-count and edge-select width; ACCUM_VAL_WIDTH, default 48, path-count width; FIFO_DEPTH, default 32, power of two >= 2, queue entries.
REQ-002 Ports: clk  in  1  sole clock, rising edge.
REQ-003 Ports: rst  in  1  reset, synchronous, active-high.
REQ-004 Ports: start_run  in  1  one-cycle start pulse, honoured only in IDLE, DONE or ERROR.
REQ-005 Ports: start_node_idx, end_node_idx  in  NODE_IDX_WIDTH each  endpoints, sampled on accepted start_run.
REQ-006 Ports: mem_rd_en  out  1; mem_node_idx  out  NODE_IDX_WIDTH; mem_edge_sel  out  COUNTER_WIDTH  adjacency read request.
REQ-007 Ports: mem_edge_count  in  COUNTER_WIDTH; mem_next_node_idx  in  NODE_IDX_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
REQ-008 Ports: busy  out  1; result_valid  out  1; result  out  ACCUM_VAL_WIDTH; err_fifo_full  out  1; err_saturated  out  1.

Function
REQ-009 States: IDLE, LOAD, POP, EDGE_REQ, EDGE_RSP, DONE, ERROR.
REQ-010 IDLE/DONE/ERROR + start_run: latch endpoints, clear queue, end accumulator, error flags and result_valid; go LOAD.
REQ-011 LOAD: push {start_node_idx, count 1}; go POP. start_node_idx == end_node_idx: end accumulator = 1, no push, go DONE.
REQ-012 POP: queue empty -> DONE; else pop head into cur_node/cur_count, clear head valid, edge index k = 0, go EDGE_REQ.
REQ-013 EDGE_REQ: mem_rd_en = 1 for exactly this cycle, mem_node_idx = cur_node, mem_edge_sel = k; go EDGE_RSP.
REQ-014 EDGE_RSP, mem_edge_count == 0: no update, go POP.
REQ-015 EDGE_RSP, mem_next_node_idx == end node: end accumulator += cur_count.
REQ-016 EDGE_RSP, otherwise: next node matches a valid queue entry -> that entry's count += cur_count, queue order unchanged; no match -> push {next node, cur_count} at tail.
REQ-017 Match search spans all FIFO_DEPTH entries in one cycle; at most one valid entry per node index at any time.
REQ-018 Push needed while queue holds FIFO_DEPTH valid entries: no write, err_fifo_full = 1, go ERROR.
REQ-019 After update: k+1 == mem_edge_count -> POP; else k += 1, go EDGE_REQ. Each edge costs exactly 2 cycles.
REQ-020 Queue is a circular buffer: read/write pointers wrap at FIFO_DEPTH; full/empty derived from pointer equality plus head-entry valid.
REQ-021 Pop and push never occur in the same cycle.
REQ-022 busy = 1 in LOAD, POP, EDGE_REQ, EDGE_RSP; else 0.
REQ-023 DONE: result_valid = 1, result = end accumulator, both held until next accepted start_run or rst.
REQ-024 ERROR: result_valid = 0, error flags held until next accepted start_run or rst.
REQ-025 start_run while busy is ignored.

Reset
REQ-026 rst = 1 at a rising edge: state IDLE, all queue entries invalid, pointers 0, accumulators 0, every output 0, including mid-run.
REQ-027 Reset release needs no extra cycles; start_run honoured on the first edge with rst = 0.

Configuration
REQ-028 Macro PATH_ACCUM_SATURATE_EN defined: every addition (queue entry and end accumulator) clamps at all-ones and sets err_saturated = 1 (sticky); run continues to DONE.
REQ-029 Macro undefined: additions wrap modulo 2^ACCUM_VAL_WIDTH; err_saturated tied to 0.

Verification
REQ-030 Chain 0->1->2, start 0, end 2 -> result_valid with result = 1; mem_rd_en pulses exactly twice.
REQ-031 Diamond 0->{1,2}, 1->3, 2->3, 3->4, start 0, end 4 -> result = 2; node 3 pushed once.
REQ-032 Fan-out of 3 from start 0 to distinct nodes, FIFO_DEPTH = 2 -> err_fifo_full = 1, state ERROR, result_valid = 0.
REQ-033 ACCUM_VAL_WIDTH = 4, 16 distinct paths to end -> with macro: result = 15, err_saturated = 1; without: result = 0.
REQ-034 rst asserted in EDGE_RSP -> next cycle busy = 0, all outputs 0; fresh start_run then gives correct result.
REQ-035 start_node_idx == end_node_idx = 5 -> result = 1 two cycles after start_run, no mem_rd_en.
